// File: rtl/ppu_dma_ctrl_if.sv
// Bus bundle for the multi-channel CPU->PPU DMA engine: register-side
// requests and channel parameters, CPU read port, destination write port
// and status. The DMA engine uses the slave view; its environment drives
// through the master view.
interface ppu_dma_ctrl_if #(
   parameter int NUM_CH = 2,
   parameter int LEN_W  = 8,
   parameter int DATA_W = 8
);
   logic                      cpu_clk_en;
   logic                      cpu_cyc_par;
   logic [NUM_CH-1:0]         start;
   logic [NUM_CH*8-1:0]       page;
   logic [NUM_CH*8-1:0]       dst_base;
   logic [NUM_CH*LEN_W-1:0]   len;
   logic                      cpu_sus;
   logic [15:0]               src_addr;
   logic                      src_re;
   logic [DATA_W-1:0]         src_rd_data;
   logic [7:0]                dst_addr;
   logic [NUM_CH-1:0]         dst_we;
   logic [DATA_W-1:0]         dst_wr_data;
   logic [NUM_CH-1:0]         busy;
   logic [NUM_CH-1:0]         done;

   modport master (
      output cpu_clk_en, cpu_cyc_par, start, page, dst_base, len, src_rd_data,
      input  cpu_sus, src_addr, src_re, dst_addr, dst_we, dst_wr_data, busy, done
   );

   modport slave (
      input  cpu_clk_en, cpu_cyc_par, start, page, dst_base, len, src_rd_data,
      output cpu_sus, src_addr, src_re, dst_addr, dst_we, dst_wr_data, busy, done
   );
endinterface

// File: rtl/ppu_dma_ctrl.sv
// Multi-channel CPU->PPU DMA engine. Each channel latches a source page,
// destination offset and length on its start pulse; pending channels are
// served lowest-index first, one READ/WRITE pair per byte, with the CPU
// suspended for the duration. All state advances only on cpu_clk_en edges.
module ppu_dma_ctrl #(
   parameter int NUM_CH = 2,
   parameter int LEN_W  = 8,
   parameter int DATA_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   ppu_dma_ctrl_if.slave  bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [LEN_W:0]   CNT_ONE = 1;
   localparam logic [LEN_W-1:0] LEN_ONE = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } state_t;

   state_t            state_reg;
   logic [CH_W-1:0]   active_reg;
   logic [LEN_W:0]    count_reg;
   logic [NUM_CH-1:0] done_reg;

   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] act_oh;
   logic [NUM_CH-1:0] others_pending;
   logic [7:0]        page_arr [NUM_CH];
   logic [7:0]        base_arr [NUM_CH];
   logic [LEN_W-1:0]  len_arr  [NUM_CH];

   logic [7:0]        page_act;
   logic [7:0]        base_act;
   logic [LEN_W-1:0]  len_m1;
   logic              last_byte;
   logic              final_write;

   // Lowest set index of a request vector (fixed priority, channel 0 first).
   function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] v);
      logic [CH_W-1:0] r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (v[i]) r = CH_W'(i);
      end
      return r;
   endfunction

   // Per-channel parameter latches; a start while the channel is still
   // queued or running is dropped so the original transfer is untouched.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic             pend_reg;
         logic [7:0]       page_reg;
         logic [7:0]       base_reg;
         logic [LEN_W-1:0] len_reg;

         // Load on an accepted start, release when this channel's last byte is written.
         always_ff @(posedge clk) begin
            if (rst) begin
               pend_reg <= 1'b0;
               page_reg <= '0;
               base_reg <= '0;
               len_reg  <= '0;
            end else if (bus.cpu_clk_en) begin
               if (bus.start[gi] && !pend_reg) begin
                  pend_reg <= 1'b1;
                  page_reg <= bus.page[gi*8 +: 8];
                  base_reg <= bus.dst_base[gi*8 +: 8];
                  len_reg  <= bus.len[gi*LEN_W +: LEN_W];
               end else if (final_write && act_oh[gi]) begin
                  pend_reg <= 1'b0;
               end
            end
         end

         assign pending[gi]  = pend_reg;
         assign page_arr[gi] = page_reg;
         assign base_arr[gi] = base_reg;
         assign len_arr[gi]  = len_reg;
         assign act_oh[gi]   = (active_reg == CH_W'(gi));
      end
   endgenerate

   assign others_pending = pending & ~act_oh;
   assign page_act       = page_arr[active_reg];
   assign base_act       = base_arr[active_reg];
   // len=0 wraps to all-ones here, so a zero length runs the full 2^LEN_W bytes.
   assign len_m1         = len_arr[active_reg] - LEN_ONE;
   assign last_byte      = (count_reg[LEN_W-1:0] == len_m1);
   assign final_write    = (state_reg == WRITE) && last_byte;

   // Transfer sequencer: channel selection, byte counter and done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         active_reg <= '0;
         count_reg  <= '0;
         done_reg   <= '0;
      end else if (bus.cpu_clk_en) begin
         done_reg <= '0;
         case (state_reg)
            IDLE: begin
               if (|pending) begin
                  active_reg <= lowest(pending);
                  state_reg  <= HALT;
               end
            end
            HALT: begin
               count_reg <= '0;
               state_reg <= bus.cpu_cyc_par ? ALIGN : READ;
            end
            ALIGN: state_reg <= READ;
            READ:  state_reg <= WRITE;
            WRITE: begin
               if (last_byte) begin
                  done_reg <= act_oh;
                  if (|others_pending) begin
                     active_reg <= lowest(others_pending);
                     state_reg  <= HALT;
                  end else begin
                     state_reg <= IDLE;
                  end
               end else begin
                  count_reg <= count_reg + CNT_ONE;
                  state_reg <= READ;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Bus outputs decoded from state and the active channel's latch.
   always_comb begin
      bus.cpu_sus     = 1'b0;
      bus.src_re      = 1'b0;
      bus.src_addr    = 16'h0000;
      bus.dst_we      = '0;
      bus.dst_addr    = 8'h00;
      bus.dst_wr_data = '0;
      if (state_reg != IDLE) begin
         // The CPU is released during the very last write of a burst.
         bus.cpu_sus = !(final_write && (others_pending == '0));
      end
      if (state_reg == READ) begin
         bus.src_re   = 1'b1;
         bus.src_addr = {page_act, 8'h00} + 16'(count_reg);
      end
      if (state_reg == WRITE) begin
         bus.dst_we      = act_oh;
         bus.dst_addr    = base_act + 8'(count_reg);
         bus.dst_wr_data = bus.src_rd_data;
      end
   end

   assign bus.busy = pending;
   assign bus.done = done_reg;

endmodule

// File: tb/tb_ppu_dma_ctrl.sv
// Directed bench for ppu_dma_ctrl: two channels, a byte-pattern CPU memory
// model and a negedge monitor logging every destination write.
module tb_ppu_dma_ctrl;
   logic clk;
   logic rst;

   ppu_dma_ctrl_if #(.NUM_CH(2), .LEN_W(8), .DATA_W(8)) bus ();

   ppu_dma_ctrl #(.NUM_CH(2), .LEN_W(8), .DATA_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [1:0] log_we   [$];
   logic [7:0] log_addr [$];
   logic [7:0] log_data [$];
   int sus_cnt, act_cnt, done0_cnt, done1_cnt, nobusy1_cnt, cyc, done0_at, done1_at;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] mem_f(input logic [15:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
   endfunction

   // Synchronous CPU memory: data appears one CPU cycle after the read strobe.
   always @(posedge clk) begin
      if (rst) bus.src_rd_data <= 8'h00;
      else if (bus.cpu_clk_en && bus.src_re) bus.src_rd_data <= mem_f(bus.src_addr);
   end

   // Monitor: one sample per CPU cycle, taken mid-cycle.
   always @(negedge clk) begin
      if (bus.cpu_clk_en) begin
         cyc++;
         if (bus.cpu_sus) sus_cnt++;
         if (bus.cpu_sus || bus.src_re || (bus.dst_we != 2'b00)) begin
            act_cnt++;
            if (!bus.busy[1]) nobusy1_cnt++;
         end
         if (bus.done[0]) begin done0_cnt++; done0_at = cyc; end
         if (bus.done[1]) begin done1_cnt++; done1_at = cyc; end
         if (bus.dst_we != 2'b00) begin
            log_we.push_back(bus.dst_we);
            log_addr.push_back(bus.dst_addr);
            log_data.push_back(bus.dst_wr_data);
            $display("wr we=%b addr=%02h data=%02h", bus.dst_we, bus.dst_addr, bus.dst_wr_data);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      log_we.delete(); log_addr.delete(); log_data.delete();
      sus_cnt = 0; act_cnt = 0; done0_cnt = 0; done1_cnt = 0;
      nobusy1_cnt = 0; cyc = 0; done0_at = 0; done1_at = 0;
   endtask

   task automatic req(input int ch, input logic [7:0] pg, input logic [7:0] base, input logic [7:0] ln);
      bus.page[ch*8 +: 8]     = pg;
      bus.dst_base[ch*8 +: 8] = base;
      bus.len[ch*8 +: 8]      = ln;
      bus.start[ch]           = 1'b1;
   endtask

   task automatic wait_idle(input int limit);
      int k;
      for (k = 0; k < limit && bus.busy != 2'b00; k++) step();
      check("idle_timeout", 32'(bus.busy), 32'd0);
      step();
   endtask

   task automatic check_log(input int first, input int n, input logic [1:0] we,
                            input logic [7:0] base, input logic [7:0] pg);
      for (int i = 0; i < n; i++) begin
         check("wr_we",   32'(log_we[first+i]),   32'(we));
         check("wr_addr", 32'(log_addr[first+i]), 32'(8'(base + 8'(i))));
         check("wr_data", 32'(log_data[first+i]), 32'(mem_f({pg, 8'h00} + 16'(i))));
      end
   endtask

   initial begin
      int k;
      clear_stats();
      rst = 1'b1;
      bus.cpu_clk_en = 1'b1; bus.cpu_cyc_par = 1'b0; bus.start = 2'b00;
      bus.page = '0; bus.dst_base = '0; bus.len = '0;
      step(); step();

      // Reset values
      check("rst_sus",    32'(bus.cpu_sus), 0);
      check("rst_src_re", 32'(bus.src_re), 0);
      check("rst_src_addr", 32'(bus.src_addr), 0);
      check("rst_dst_we", 32'(bus.dst_we), 0);
      check("rst_dst_addr", 32'(bus.dst_addr), 0);
      check("rst_dst_data", 32'(bus.dst_wr_data), 0);
      check("rst_busy",   32'(bus.busy), 0);
      check("rst_done",   32'(bus.done), 0);
      rst = 1'b0;
      step();

      // Basic 256-byte transfer on channel 0
      $display("test basic 256-byte ch0");
      clear_stats();
      req(0, 8'h02, 8'h00, 8'h00);
      step(); bus.start = 2'b00;
      check("b_busy_idle", 32'(bus.busy), 32'h1);
      check("b_sus_idle", 32'(bus.cpu_sus), 0);
      step();
      check("b_sus_halt", 32'(bus.cpu_sus), 1);
      check("b_re_halt", 32'(bus.src_re), 0);
      step();
      check("b_re_read", 32'(bus.src_re), 1);
      check("b_addr_read", 32'(bus.src_addr), 32'h0200);
      wait_idle(600);
      check("b_nwr", 32'(log_we.size()), 256);
      check_log(0, 256, 2'b01, 8'h00, 8'h02);
      check("b_sus_cnt", 32'(sus_cnt), 512);
      check("b_act_cnt", 32'(act_cnt), 513);
      check("b_done0", 32'(done0_cnt), 1);
      check("b_done1", 32'(done1_cnt), 0);

      // Alignment cycle
      $display("test align par=1");
      clear_stats();
      bus.cpu_cyc_par = 1'b1;
      req(0, 8'h05, 8'h00, 8'h00);
      step(); bus.start = 2'b00;
      step();
      check("a_re_halt", 32'(bus.src_re), 0);
      step();
      check("a_re_align", 32'(bus.src_re), 0);
      check("a_sus_align", 32'(bus.cpu_sus), 1);
      step();
      check("a_re_read", 32'(bus.src_re), 1);
      check("a_addr_read", 32'(bus.src_addr), 32'h0500);
      bus.cpu_cyc_par = 1'b0;
      wait_idle(600);
      check("a_nwr", 32'(log_we.size()), 256);
      check_log(0, 256, 2'b01, 8'h00, 8'h05);
      check("a_sus_cnt", 32'(sus_cnt), 513);
      check("a_act_cnt", 32'(act_cnt), 514);

      // Destination wrap on channel 1
      $display("test dst wrap ch1");
      clear_stats();
      req(1, 8'h03, 8'hF0, 8'h20);
      step(); bus.start = 2'b00;
      check("w_busy", 32'(bus.busy), 32'h2);
      wait_idle(200);
      check("w_nwr", 32'(log_we.size()), 32);
      check_log(0, 32, 2'b10, 8'hF0, 8'h03);
      check("w_done1", 32'(done1_cnt), 1);
      check("w_done0", 32'(done0_cnt), 0);

      // Simultaneous requests
      $display("test simultaneous ch0+ch1");
      clear_stats();
      req(0, 8'h06, 8'h10, 8'h04);
      req(1, 8'h07, 8'h20, 8'h03);
      step(); bus.start = 2'b00;
      check("s_busy", 32'(bus.busy), 32'h3);
      wait_idle(200);
      check("s_nwr", 32'(log_we.size()), 7);
      check_log(0, 4, 2'b01, 8'h10, 8'h06);
      check_log(4, 3, 2'b10, 8'h20, 8'h07);
      check("s_sus_cnt", 32'(sus_cnt), 15);
      check("s_act_cnt", 32'(act_cnt), 16);
      check("s_nobusy1", 32'(nobusy1_cnt), 0);
      check("s_done0", 32'(done0_cnt), 1);
      check("s_done1", 32'(done1_cnt), 1);
      check("s_done_order", 32'(done0_at < done1_at), 1);

      // Reset mid-transfer
      $display("test reset mid-transfer");
      clear_stats();
      req(0, 8'h08, 8'h00, 8'h00);
      step(); bus.start = 2'b00;
      for (k = 0; k < 400 && log_we.size() < 100; k++) step();
      check("r_reach100", 32'(log_we.size()), 100);
      rst = 1'b1;
      step();
      check("r_sus",    32'(bus.cpu_sus), 0);
      check("r_src_re", 32'(bus.src_re), 0);
      check("r_src_addr", 32'(bus.src_addr), 0);
      check("r_dst_we", 32'(bus.dst_we), 0);
      check("r_dst_addr", 32'(bus.dst_addr), 0);
      check("r_dst_data", 32'(bus.dst_wr_data), 0);
      check("r_busy",   32'(bus.busy), 0);
      check("r_done",   32'(bus.done), 0);
      rst = 1'b0;
      for (k = 0; k < 5; k++) step();
      check("r_nowr", 32'(log_we.size()), 100);
      req(0, 8'h09, 8'h00, 8'h02);
      step(); bus.start = 2'b00;
      step();
      step();
      check("r_restart_addr", 32'(bus.src_addr), 32'h0900);
      wait_idle(50);
      check("r_nwr2", 32'(log_we.size()), 102);
      check_log(100, 2, 2'b01, 8'h00, 8'h09);

      // Ignored start and enable gating
      $display("test ignored start + enable gating");
      clear_stats();
      req(0, 8'h0A, 8'h40, 8'h08);
      step(); bus.start = 2'b00;
      step(); step(); step(); step();
      req(0, 8'h0B, 8'h00, 8'h02);
      step(); bus.start = 2'b00;
      check("g_busy", 32'(bus.busy), 32'h1);
      step();
      check("g_addr_c2", 32'(bus.src_addr), 32'h0A02);
      bus.cpu_clk_en = 1'b0;
      for (k = 0; k < 5; k++) begin
         step();
         check("g_frz_addr", 32'(bus.src_addr), 32'h0A02);
         check("g_frz_re", 32'(bus.src_re), 1);
      end
      bus.cpu_clk_en = 1'b1;
      wait_idle(100);
      check("g_nwr", 32'(log_we.size()), 8);
      check_log(0, 8, 2'b01, 8'h40, 8'h0A);
      check("g_sus_cnt", 32'(sus_cnt), 16);
      check("g_act_cnt", 32'(act_cnt), 17);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/ppu_dma_ctrl.md
# ppu_dma_ctrl

Parametrised multi-channel CPU→PPU DMA engine. It generalises the single-channel, fixed-256-byte OAMDMA sequencer to NUM_CH channels, each with its own source page, destination base offset and transfer length. Requests that arrive while a transfer is running are queued and served by fixed priority. The block sits between the PPU register interface, which issues per-channel start pulses, the CPU memory read port, and the destination RAMs (OAM and any secondary sprite/attribute buffers). It suspends the CPU for the whole time it is running.

## Interface
- NUM_CH, 2, number of DMA channels (1..4).
- LEN_W, 8, transfer-length field width (1..8). A length of 0 means 2^LEN_W bytes.
- DATA_W, 8, data width.

- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- cpu_clk_en  in  1  CPU clock enable. All state advances only on clk edges where this is 1.
- cpu_cyc_par  in  1  CPU cycle parity. 1 = an alignment cycle is required.
- start  in  NUM_CH  per-channel request. Sampled on cpu_clk_en edges.
- page  in  NUM_CH*8  source high byte per channel. Latched with start.
- dst_base  in  NUM_CH*8  destination start offset. Latched with start.
- len  in  NUM_CH*LEN_W  byte count. Latched with start.
- cpu_sus  out  1  CPU suspend.
- src_addr  out  16  CPU read address.
- src_re  out  1  CPU read strobe.
- src_rd_data  in  DATA_W  CPU read data. Synchronous: valid one CPU cycle after src_re.
- dst_addr  out  8  destination address for the active channel.
- dst_we  out  NUM_CH  one-hot destination write enable.
- dst_wr_data  out  DATA_W  destination write data.
- busy  out  NUM_CH  channel is queued or active.
- done  out  NUM_CH  completion pulse, one CPU cycle long.

## Operation
- **Channel latch.** Each channel has a latch holding page, dst_base, len and a pending bit.
  - start[i] with busy[i]=0 loads the latch and sets pending[i].
  - start[i] with busy[i]=1 is ignored.
- **State machine.** States are IDLE, HALT, ALIGN, READ, WRITE.
  - IDLE → HALT when any channel is pending. The active channel is the lowest pending index; it is fixed until that transfer completes.
  - HALT: the byte counter is cleared. Next state is ALIGN if cpu_cyc_par=1, otherwise READ.
  - ALIGN → READ.
  - READ: src_re=1 and src_addr={page,8'h00}+count (16-bit, wraps). Next state is WRITE.
  - WRITE:
    - dst_we[active]=1, dst_addr=(dst_base+count) mod 256, dst_wr_data=src_rd_data.
    - If count=len-1 (modulo 2^LEN_W, so len=0 ends at 2^LEN_W-1): clear pending[active], pulse done[active], then go to HALT if another channel is pending, otherwise IDLE.
    - Otherwise increment count and go to READ.
- **Counter.** The counter is LEN_W+1 bits wide, so the len=0 case counts the full 2^LEN_W bytes.
- **CPU suspend.** cpu_sus=1 in HALT, ALIGN, READ and WRITE, except in the final WRITE when no other channel is pending; there it is 0. Back-to-back channels keep cpu_sus continuously high.
- **Strobes.** src_re=0 and dst_we=0 outside READ and WRITE respectively. dst_addr and dst_wr_data are 0 when dst_we is all zeros.
- **busy.** busy[i] = pending[i].
- **Reset.** rst at any time, including mid-transfer, returns the state to IDLE and clears all pending bits, latches, the counter and the done register. No further dst_we is asserted. rst takes precedence over cpu_clk_en.

## Timing
- Reset values: cpu_sus=0, src_re=0, src_addr=0, dst_we=0, dst_addr=0, dst_wr_data=0, busy=0, done=0.
- Outputs other than done are combinational from state and latches, so they change only after cpu_clk_en edges.
- done[i] is registered:
  - set on the enabled edge that leaves the final WRITE;
  - cleared on the next enabled edge.
- Latency from start to first HALT: 1 CPU cycle.
- Duration for N bytes: 1 + par + 2N CPU cycles of cpu_sus, minus the final WRITE, which runs with cpu_sus=0.
  - 256 bytes, par=0: 513 cycles total, 512 of them with cpu_sus=1.
- cpu_clk_en=0 freezes every state element and ignores start.

## Test plan
- **Basic 256-byte transfer.** start[0], page=0x02, len=0, dst_base=0x00, par=0 → HALT, then 256 READ/WRITE pairs; dst_addr 0x00..0xFF carries mem[0x0200..0x02FF]; done[0] pulses once; cpu_sus=1 for exactly 512 CPU cycles.
- **Alignment cycle.** Same as the basic transfer with par=1 in HALT → one ALIGN cycle, no src_re during HALT or ALIGN, first READ one cycle later; total 514 cycles.
- **Destination wrap.** start[1], len=0x20, dst_base=0xF0, page=0x03 → dst_we[1] writes addresses 0xF0..0xFF then 0x00..0x0F with mem[0x0300..0x031F]; dst_we[0] never asserted.
- **Simultaneous requests.** start[0] and start[1] on the same cycle → channel 0 completes first, then HALT for channel 1 immediately with cpu_sus unbroken; done[0] pulses before done[1]; busy[1] stays 1 throughout.
- **Reset mid-transfer.** rst asserted after 100 writes → next cycle all outputs are at reset values and no further writes occur; a new start[0] restarts from count 0.
- **Ignored start and enable gating.** start[0] while busy[0]=1 → ignored, with the original page and len retained. Holding cpu_clk_en=0 for 5 clk cycles mid-transfer → state and src_addr are unchanged.
